// File: rtl/typing_game_ctrl_if.sv
// typing_game_ctrl_if: stimulus inputs and slot/score/state outputs of the typing game controller
interface typing_game_ctrl_if;
  logic        tick;
  logic        start;
  logic [7:0]  rnd_ascii;
  logic [5:0]  rnd_x;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic [3:0]  slot_valid;
  logic [31:0] slot_ascii;
  logic [23:0] slot_x;
  logic [19:0] slot_y;
  logic [3:0]  score_h;
  logic [3:0]  score_l;
  logic [3:0]  miss_cnt;
  logic [1:0]  state;
  logic        pause;
  modport master (
    output tick, start, rnd_ascii, rnd_x, key_valid, key_ascii,
    input  slot_valid, slot_ascii, slot_x, slot_y, score_h, score_l, miss_cnt, state, pause
  );
  modport slave (
    input  tick, start, rnd_ascii, rnd_x, key_valid, key_ascii,
    output slot_valid, slot_ascii, slot_x, slot_y, score_h, score_l, miss_cnt, state, pause
  );
endinterface

// File: rtl/typing_game_ctrl.sv
// typing_game_ctrl: four falling-letter slots, keystroke matching, BCD score, miss count and game FSM
module typing_game_ctrl #(
  parameter int SPAWN_DIV  = 4,
  parameter int BOTTOM_ROW = 29,
  parameter int MAX_MISS   = 9
) (
  input logic clk_50,
  input logic rst,
  typing_game_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  state_t          r_state, w_state;
  logic [3:0]      r_valid, w_valid, w_free;
  logic [3:0][7:0] r_ascii, w_ascii;
  logic [3:0][5:0] r_x, w_x;
  logic [3:0][4:0] r_y, w_y;
  logic [3:0]      r_sh, w_sh, r_sl, w_sl, r_miss, w_miss, r_cnt, w_cnt;
  logic            r_pause;
  logic [7:0]      w_key;
  logic            w_match, w_hit, w_wrap;
  logic [1:0]      w_hit_idx, w_sp_idx;
  logic [2:0]      w_lost;
  logic [4:0]      w_miss_sum;
  assign w_key  = (bus.key_ascii >= 8'h61 && bus.key_ascii <= 8'h7A) ? bus.key_ascii - 8'h20 : bus.key_ascii;
  assign w_free = ~r_valid;
  assign w_wrap = r_cnt == 4'(SPAWN_DIV - 1);
  assign w_hit  = bus.key_valid && w_match;
  // descending scan leaves the lowest matching / lowest free index
  always_comb begin
    w_match   = 1'b0;
    w_hit_idx = 2'd0;
    w_sp_idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_valid[i] && r_ascii[i] == w_key) begin
        w_match   = 1'b1;
        w_hit_idx = 2'(i);
      end
      if (w_free[i]) w_sp_idx = 2'(i);
    end
  end
  always_comb begin
    w_state    = r_state;
    w_valid    = r_valid;
    w_ascii    = r_ascii;
    w_x        = r_x;
    w_y        = r_y;
    w_sh       = r_sh;
    w_sl       = r_sl;
    w_miss     = r_miss;
    w_cnt      = r_cnt;
    w_lost     = '0;
    w_miss_sum = {1'b0, r_miss};
    if (bus.start) begin
      w_state = PLAY;
      w_valid = '0;
      w_sh    = '0;
      w_sl    = '0;
      w_miss  = '0;
      w_cnt   = '0;
    end else if (r_state == PLAY) begin
      if (w_hit) begin
        w_valid[w_hit_idx] = 1'b0;
        w_sl = (r_sl == 4'd9) ? 4'd0 : r_sl + 4'd1;
        w_sh = (r_sl != 4'd9) ? r_sh : (r_sh == 4'd9) ? 4'd0 : r_sh + 4'd1;
      end
      if (bus.tick) begin
        // the slot just hit is already invalid here, so it neither falls nor misses
        for (int i = 0; i < 4; i++) begin
          if (w_valid[i]) begin
            if (r_y[i] == 5'(BOTTOM_ROW)) begin
              w_valid[i] = 1'b0;
              w_lost     = w_lost + 3'd1;
            end else begin
              w_y[i] = r_y[i] + 5'd1;
            end
          end
        end
        w_miss_sum = {1'b0, r_miss} + {2'b0, w_lost};
        w_miss     = (w_miss_sum > 5'd15) ? 4'd15 : w_miss_sum[3:0];
        w_cnt      = w_wrap ? 4'd0 : r_cnt + 4'd1;
        if (w_wrap && |w_free) begin
          w_valid[w_sp_idx] = 1'b1;
          w_ascii[w_sp_idx] = bus.rnd_ascii;
          w_x[w_sp_idx]     = bus.rnd_x;
          w_y[w_sp_idx]     = '0;
        end
        if (w_miss >= 4'(MAX_MISS)) w_state = OVER;
      end
    end
  end
  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_ascii <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_sh    <= '0;
      r_sl    <= '0;
      r_miss  <= '0;
      r_cnt   <= '0;
      r_pause <= 1'b1;
    end else begin
      r_state <= w_state;
      r_valid <= w_valid;
      r_ascii <= w_ascii;
      r_x     <= w_x;
      r_y     <= w_y;
      r_sh    <= w_sh;
      r_sl    <= w_sl;
      r_miss  <= w_miss;
      r_cnt   <= w_cnt;
      r_pause <= w_state != PLAY;
    end
  end
  assign bus.slot_valid = r_valid;
  assign bus.slot_ascii = r_ascii;
  assign bus.slot_x     = r_x;
  assign bus.slot_y     = r_y;
  assign bus.score_h    = r_sh;
  assign bus.score_l    = r_sl;
  assign bus.miss_cnt   = r_miss;
  assign bus.state      = r_state;
  assign bus.pause      = r_pause;
endmodule

// File: tb/tb_typing_game_ctrl.sv
// tb_typing_game_ctrl: directed and random stimulus against a list-based game model, two MAX_MISS settings
module tb_typing_game_ctrl;
  localparam int DIV = 4;
  localparam int BR  = 29;
  logic       clk_50 = 1'b0;
  logic       rst = 1'b1, tick = 1'b0, start = 1'b0, key_valid = 1'b0;
  logic [7:0] rnd_ascii = 8'h41, key_ascii = 8'h00;
  logic [5:0] rnd_x = 6'd0;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int mv[2][4], ma[2][4], mx[2][4], my[2][4];
  int msc[2], mmiss[2], mst[2], mcnt[2];
  int mmax[2] = '{9, 1};
  always #5 clk_50 = ~clk_50;
  typing_game_ctrl_if ia();
  typing_game_ctrl_if ib();
  assign ia.tick = tick;      assign ib.tick = tick;
  assign ia.start = start;    assign ib.start = start;
  assign ia.rnd_ascii = rnd_ascii; assign ib.rnd_ascii = rnd_ascii;
  assign ia.rnd_x = rnd_x;    assign ib.rnd_x = rnd_x;
  assign ia.key_valid = key_valid; assign ib.key_valid = key_valid;
  assign ia.key_ascii = key_ascii; assign ib.key_ascii = key_ascii;
  typing_game_ctrl dut_a (.clk_50(clk_50), .rst(rst), .bus(ia.slave));
  typing_game_ctrl #(.MAX_MISS(1)) dut_b (.clk_50(clk_50), .rst(rst), .bus(ib.slave));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // game rules applied to plain integer slot lists, one copy per DUT
  task automatic model_step;
    int fr[4];
    int m, kk, lost, sp;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          mv[k][i] = 0; ma[k][i] = 0; mx[k][i] = 0; my[k][i] = 0;
        end
        msc[k] = 0; mmiss[k] = 0; mst[k] = 0; mcnt[k] = 0;
      end else if (start) begin
        for (int i = 0; i < 4; i++) mv[k][i] = 0;
        msc[k] = 0; mmiss[k] = 0; mst[k] = 1; mcnt[k] = 0;
      end else if (mst[k] == 1) begin
        m = -1;
        kk = int'(key_ascii);
        if (kk >= 97 && kk <= 122) kk -= 32;
        for (int i = 0; i < 4; i++) begin
          fr[i] = (mv[k][i] == 0) ? 1 : 0;
          if (key_valid && m < 0 && mv[k][i] != 0 && ma[k][i] == kk) m = i;
        end
        if (m >= 0) begin
          mv[k][m] = 0;
          msc[k] = (msc[k] + 1) % 100;
        end
        if (tick) begin
          lost = 0;
          for (int i = 0; i < 4; i++)
            if (mv[k][i] != 0) begin
              if (my[k][i] == BR) begin mv[k][i] = 0; lost++; end
              else my[k][i]++;
            end
          mmiss[k] = (mmiss[k] + lost > 15) ? 15 : mmiss[k] + lost;
          mcnt[k] = (mcnt[k] + 1) % DIV;
          if (mcnt[k] == 0) begin
            sp = -1;
            for (int i = 0; i < 4; i++) if (sp < 0 && fr[i] != 0) sp = i;
            if (sp >= 0) begin
              mv[k][sp] = 1; ma[k][sp] = int'(rnd_ascii); mx[k][sp] = int'(rnd_x); my[k][sp] = 0;
            end
          end
          if (mmiss[k] >= mmax[k]) mst[k] = 2;
        end
      end
    end
  endtask
  task automatic cmp(input int k, input logic [3:0] v, input logic [31:0] a, input logic [23:0] x,
                     input logic [19:0] y, input logic [3:0] sh, input logic [3:0] sl,
                     input logic [3:0] mc, input logic [1:0] st, input logic p);
    logic [3:0] ev;
    logic [31:0] ea;
    logic [23:0] ex;
    logic [19:0] ey;
    string pre;
    pre = (k != 0) ? "b." : "a.";
    for (int i = 0; i < 4; i++) begin
      ev[i] = mv[k][i] != 0;
      ea[8*i +: 8] = 8'(ma[k][i]);
      ex[6*i +: 6] = 6'(mx[k][i]);
      ey[5*i +: 5] = 5'(my[k][i]);
    end
    chk({pre, "slot_valid"}, 32'(v), 32'(ev));
    chk({pre, "slot_ascii"}, a, ea);
    chk({pre, "slot_x"}, 32'(x), 32'(ex));
    chk({pre, "slot_y"}, 32'(y), 32'(ey));
    chk({pre, "score_h"}, 32'(sh), msc[k] / 10);
    chk({pre, "score_l"}, 32'(sl), msc[k] % 10);
    chk({pre, "miss_cnt"}, 32'(mc), mmiss[k]);
    chk({pre, "state"}, 32'(st), mst[k]);
    chk({pre, "pause"}, 32'(p), (mst[k] != 1) ? 1 : 0);
  endtask
  always @(negedge clk_50)
    if (chk_en) begin
      cmp(0, ia.slot_valid, ia.slot_ascii, ia.slot_x, ia.slot_y, ia.score_h, ia.score_l, ia.miss_cnt, ia.state, ia.pause);
      cmp(1, ib.slot_valid, ib.slot_ascii, ib.slot_x, ib.slot_y, ib.score_h, ib.score_l, ib.miss_cnt, ib.state, ib.pause);
    end
  task automatic cyc(input int r, input int s, input int t, input int kv, input int k);
    rst = r != 0; start = s != 0; tick = t != 0; key_valid = kv != 0; key_ascii = 8'(k);
    @(posedge clk_50);
    model_step();
    #1;
  endtask
  initial begin
    logic [7:0] kk;
    logic [3:0] sv;
    logic [19:0] ey;
    int j;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_state", 32'(ia.state), 0);
    chk("rst_pause", 32'(ia.pause), 1);
    chk("rst_valid", 32'(ia.slot_valid), 0);
    rnd_ascii = 8'h41; rnd_x = 6'd5;
    cyc(0, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0);
    chk("spawn_valid", 32'(ia.slot_valid), 1);
    chk("spawn_ascii", 32'(ia.slot_ascii[7:0]), 32'h41);
    chk("spawn_x", 32'(ia.slot_x[5:0]), 5);
    chk("spawn_y", 32'(ia.slot_y[4:0]), 0);
    chk("spawn_pause", 32'(ia.pause), 0);
    cyc(0, 0, 0, 1, 8'h61);
    chk("hit_valid", 32'(ia.slot_valid), 0);
    chk("hit_score", 32'({ia.score_h, ia.score_l}), 32'h01);
    cyc(0, 0, 0, 1, 8'h42);
    chk("nomatch_valid", 32'(ia.slot_valid), 0);
    chk("nomatch_score", 32'({ia.score_h, ia.score_l}), 32'h01);
    repeat (34) cyc(0, 0, 1, 0, 0);
    chk("over_miss", 32'(ib.miss_cnt), 1);
    chk("over_state", 32'(ib.state), 2);
    chk("over_pause", 32'(ib.pause), 1);
    chk("a_still_play", 32'(ia.state), 1);
    sv = ib.slot_valid;
    repeat (6) cyc(0, 0, 1, 1, int'(ib.slot_ascii[7:0]));
    chk("over_hold_valid", 32'(ib.slot_valid), 32'(sv));
    chk("over_hold_score", 32'({ib.score_h, ib.score_l}), 32'h01);
    chk("over_hold_state", 32'(ib.state), 2);
    rnd_ascii = 8'h42; rnd_x = 6'd7;
    cyc(0, 1, 0, 0, 0);
    repeat (20) cyc(0, 0, 1, 0, 0);
    ey = {5'd4, 5'd8, 5'd12, 5'd16};
    chk("full_valid", 32'(ia.slot_valid), 32'hF);
    chk("full_ascii", ia.slot_ascii, 32'h42424242);
    chk("full_y", 32'(ia.slot_y), 32'(ey));
    repeat (13) cyc(0, 0, 1, 0, 0);
    chk("bottom_y0", 32'(ia.slot_y[4:0]), BR);
    cyc(0, 0, 1, 1, 8'h62);
    chk("coll_valid", 32'(ia.slot_valid), 32'hE);
    chk("coll_score", 32'({ia.score_h, ia.score_l}), 32'h01);
    chk("coll_miss", 32'(ia.miss_cnt), 0);
    cyc(0, 1, 0, 0, 0);
    for (int h = 1; h <= 100; h++) begin
      rnd_ascii = 8'($urandom_range(65, 90));
      repeat (4) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, ($urandom_range(0, 1) != 0) ? int'(rnd_ascii | 8'h20) : int'(rnd_ascii));
      if (h == 99) chk("score_99", 32'({ia.score_h, ia.score_l}), 32'h99);
    end
    chk("score_wrap", 32'({ia.score_h, ia.score_l}), 32'h00);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 1, 1, 1, 8'h41);
    chk("mid_rst_state", 32'(ia.state), 0);
    chk("mid_rst_pause", 32'(ia.pause), 1);
    chk("mid_rst_valid", 32'(ia.slot_valid), 0);
    chk("mid_rst_ascii", ia.slot_ascii, 0);
    chk("mid_rst_x", 32'(ia.slot_x), 0);
    chk("mid_rst_y", 32'(ia.slot_y), 0);
    chk("mid_rst_score", 32'({ia.score_h, ia.score_l}), 0);
    chk("mid_rst_miss", 32'(ia.miss_cnt), 0);
    for (int n = 0; n < 4000; n++) begin
      rnd_ascii = 8'($urandom_range(65, 90));
      rnd_x = 6'($urandom);
      j = $urandom_range(0, 3);
      kk = 8'(ma[0][j]);
      if ($urandom_range(0, 1) != 0) kk = kk | 8'h20;
      if ($urandom_range(0, 7) == 0) kk = 8'($urandom);
      cyc(($urandom_range(0, 499) == 0) ? 1 : 0, ($urandom_range(0, 149) == 0) ? 1 : 0,
          $urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? 1 : 0, int'(kk));
    end
    @(negedge clk_50);
    #1;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
